region_color_manager: RTL and testbench
=======================================

Name: region_color_manager

Overview:
- Parametrised successor of the quadrant color manager.
- Receives two-byte configuration commands from the UART RX FIFO and stores one color per screen region in an H_REGIONS x V_REGIONS grid.
- Mirrors each color write to the external config memory over a valid/ready handshake.
- Drives Data_VGA from internal pixel counters using the region color selected by the current split mode.

Parameters:
- UART_DATA_WIDTH, 8, RX byte width; fixed at 8.
- COLOR_WIDTH, 8, color word width on C_Data and Data_VGA.
- H_REGIONS, 2, region columns, 1..8.
- V_REGIONS, 2, region rows, 1..8; H_REGIONS*V_REGIONS <= 64.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- C_ADDR_WIDTH, 6, config memory address width.
- TIMEOUT_CYCLES, 1024, maximum wait for the second command byte.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset, asynchronous, active-low.
- Empty  in  1  RX FIFO empty (first-word-fall-through).
- RXD_Data  in  UART_DATA_WIDTH  FIFO head byte.
- RXD_Rd  out  1  one-cycle FIFO pop.
- C_Rdy  in  1  config memory ready.
- C_Addr  out  C_ADDR_WIDTH  region index, zero-extended.
- C_Data  out  COLOR_WIDTH  color.
- C_Valid  out  1  write request.
- HSync  in  1  line sync, active-high.
- VSync  in  1  frame sync, active-high.
- De  in  1  display enable.
- Config_Status  out  2  00 IDLE, 01 WAIT_DATA, 10 WRITE.
- Config_Notification  out  2  01 color written, 10 mode changed.
- Config_Notification_Valid  out  1  one-cycle pulse.
- Config_Error  out  2  01 bad region, 10 bad opcode, 11 timeout.
- Error_Valid  out  1  one-cycle pulse.
- Split_Mode  out  2  current mode.
- Data_VGA  out  COLOR_WIDTH  pixel color.

Behaviour:
- Reset: all outputs 0, all region colors 0, Split_Mode 0, FSM IDLE, counters 0. Rst low mid-handshake drops C_Valid immediately; the command is lost.
- Header byte: [7:6] opcode (00 set color, 01 set mode, 1x invalid), [5:0] region index.
- IDLE, Empty=0: RXD_Rd=1 and header captured in the same cycle.
  - Opcode 00 with region < H_REGIONS*V_REGIONS -> WAIT_DATA.
  - Opcode 00 with region out of range -> Error_Valid, code 01, stay IDLE.
  - Opcode 01 -> WAIT_DATA.
  - Opcode 1x -> error 10, stay IDLE.
- WAIT_DATA: timeout counter clears on entry.
  - Empty=0: pop and capture the byte.
  - Opcode 00: region color updated that cycle -> WRITE.
  - Opcode 01: Split_Mode <= byte[1:0], notification 10 -> IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 with Empty=1: error 11 -> IDLE, header discarded.
- WRITE: C_Valid=1 with C_Addr/C_Data stable until C_Rdy is sampled high. Next cycle: C_Valid=0, notification 01 -> IDLE. No FIFO pops occur during WRITE.
- Pulses: notification and error pulses are exactly one cycle. Byte consumption is at most one byte per cycle.
- Pixel counters:
  - Rising edge of HSync (registered edge detect) clears x, col and the in-region counter, and increments y (saturating at V_ACTIVE-1).
  - Rising edge of VSync clears y and row; it has priority when coincident with HSync.
  - x increments on De=1.
  - REGION_W = H_ACTIVE/H_REGIONS. col increments when the in-region counter reaches REGION_W-1 and saturates at H_REGIONS-1, so remainder pixels belong to the last column. Rows behave identically with REGION_H.
- Region select by Split_Mode: 0 -> region 0; 1 -> col; 2 -> row*H_REGIONS; 3 -> row*H_REGIONS+col.
- Data_VGA: registered, 1-cycle latency from De. Outputs 0 when De=0. A color update is visible on the next pixel after the update cycle.

Optional Feature:
- Macro: COLOR_MANAGER_DEBUG_PATTERN_EN.
- Defined: adds input VGA_Debugg (1 bit). When VGA_Debugg=1, Data_VGA = selected region index zero-extended to COLOR_WIDTH, ignoring stored colors. Latency is unchanged.
- Undefined: the port is absent and stored colors are always used.

Test Plan:
- Bytes 0x03, 0x5A via FIFO with C_Rdy low for 5 cycles -> C_Valid high 5+ cycles, C_Addr=3, C_Data=0x5A; one notification 01 after C_Rdy.
- Header 0x05 (2x2 grid) -> Error_Valid with code 01, one pop, FSM stays IDLE; header 0xC0 -> code 10.
- Header 0x01, then Empty held for TIMEOUT_CYCLES -> error 11; the next 0x01, 0x22 writes region 1=0x22.
- Colors 0x10/0x20/0x30/0x40, mode 3, full frame -> Data_VGA 0x10 at (0,0), 0x20 at (320,0), 0x30 at (0,240), 0x40 at (639,479), 1-cycle latency; mode 1 gives 0x10/0x20 only.
- Rst deasserted (driven low) while C_Valid=1 -> C_Valid=0 asynchronously, all colors 0, Data_VGA 0.
- H_REGIONS=3, H_ACTIVE=640 -> columns split at x=213 and 426; x=639 maps to col 2.

Source files
------------

// File: rtl/region_color_manager.sv
// Region color manager: UART-fed per-region color table, config-memory mirror and VGA pixel color select.
// Optional debug pattern (region index as pixel color) enabled by COLOR_MANAGER_DEBUG_PATTERN_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a header byte from the RX FIFO
// ST_WAIT   | header accepted, waiting for the data byte (timeout armed)
// ST_WRITE  | color stored, mirroring it to config memory via C_Valid/C_Rdy
module region_color_manager #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int COLOR_WIDTH     = 8,
    parameter int H_REGIONS       = 2,
    parameter int V_REGIONS       = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int C_ADDR_WIDTH    = 6,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Empty,
    input  logic [UART_DATA_WIDTH-1:0] RXD_Data,
    output logic                       RXD_Rd,
    input  logic                       C_Rdy,
    output logic [C_ADDR_WIDTH-1:0]    C_Addr,
    output logic [COLOR_WIDTH-1:0]     C_Data,
    output logic                       C_Valid,
    input  logic                       HSync,
    input  logic                       VSync,
    input  logic                       De,
    output logic [1:0]                 Config_Status,
    output logic [1:0]                 Config_Notification,
    output logic                       Config_Notification_Valid,
    output logic [1:0]                 Config_Error,
    output logic                       Error_Valid,
    output logic [1:0]                 Split_Mode,
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
    input  logic                       VGA_Debugg,
`endif
    output logic [COLOR_WIDTH-1:0]     Data_VGA
);

    localparam int N_REGIONS = H_REGIONS * V_REGIONS;
    localparam int REGION_W  = H_ACTIVE / H_REGIONS;
    localparam int REGION_H  = V_ACTIVE / V_REGIONS;
    localparam int COL_W     = (H_REGIONS > 1) ? $clog2(H_REGIONS) : 1;
    localparam int ROW_W     = (V_REGIONS > 1) ? $clog2(V_REGIONS) : 1;
    localparam int X_W       = $clog2(H_ACTIVE + 1);
    localparam int Y_W       = $clog2(V_ACTIVE + 1);
    localparam int XR_W      = $clog2(REGION_W + 1);
    localparam int YR_W      = $clog2(REGION_H + 1);
    localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    logic [1:0]             state;
    logic                   hdr_is_mode;
    logic [5:0]             hdr_idx;
    logic [COLOR_WIDTH-1:0] wr_data;
    logic [TMR_W-1:0]       tmr;
    logic [COLOR_WIDTH-1:0] colors [N_REGIONS];
    logic [1:0]             split_mode;
    logic [1:0]             notif, err;
    logic                   notif_v, err_v;

    // Gated with Rst so the FIFO is never popped while held in reset.
    assign RXD_Rd  = Rst && !Empty && ((state == ST_IDLE) || (state == ST_WAIT));
    assign C_Valid = (state == ST_WRITE);
    assign C_Addr  = C_ADDR_WIDTH'(hdr_idx);
    assign C_Data  = wr_data;
    assign Config_Status             = state;
    assign Config_Notification       = notif;
    assign Config_Notification_Valid = notif_v;
    assign Config_Error              = err;
    assign Error_Valid               = err_v;
    assign Split_Mode                = split_mode;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            hdr_is_mode <= 1'b0;
            hdr_idx     <= '0;
            wr_data     <= '0;
            tmr         <= '0;
            split_mode  <= '0;
            notif       <= '0;
            notif_v     <= 1'b0;
            err         <= '0;
            err_v       <= 1'b0;
            for (int i = 0; i < N_REGIONS; i++) colors[i] <= '0;
        end else begin
            notif_v <= 1'b0;
            err_v   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Empty) begin
                        hdr_is_mode <= RXD_Data[6];
                        hdr_idx     <= RXD_Data[5:0];
                        tmr         <= TMR_W'(TIMEOUT_CYCLES - 1);
                        if (RXD_Data[7]) begin
                            err   <= 2'b10;
                            err_v <= 1'b1;
                        end else if (!RXD_Data[6] && (32'(RXD_Data[5:0]) >= N_REGIONS)) begin
                            err   <= 2'b01;
                            err_v <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!Empty) begin
                        if (hdr_is_mode) begin
                            split_mode <= RXD_Data[1:0];
                            notif      <= 2'b10;
                            notif_v    <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            for (int i = 0; i < N_REGIONS; i++)
                                if (hdr_idx == 6'(i)) colors[i] <= COLOR_WIDTH'(RXD_Data);
                            wr_data <= COLOR_WIDTH'(RXD_Data);
                            state   <= ST_WRITE;
                        end
                    end else if (tmr == '0) begin
                        err   <= 2'b11;
                        err_v <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (C_Rdy) begin
                        notif   <= 2'b01;
                        notif_v <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic             hs_q, vs_q;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [XR_W-1:0]  xr;
    logic [YR_W-1:0]  yr;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             h_rise, v_rise;

    assign h_rise = HSync && !hs_q;
    assign v_rise = VSync && !vs_q;

    // The last column/row absorbs remainder pixels because col/row saturate.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            x    <= '0;
            y    <= '0;
            xr   <= '0;
            yr   <= '0;
            col  <= '0;
            row  <= '0;
        end else begin
            hs_q <= HSync;
            vs_q <= VSync;
            if (h_rise) begin
                x   <= '0;
                xr  <= '0;
                col <= '0;
            end else if (De && (x != X_W'(H_ACTIVE - 1))) begin
                x <= x + 1'b1;
                if (xr == XR_W'(REGION_W - 1)) begin
                    xr <= '0;
                    if (col != COL_W'(H_REGIONS - 1)) col <= col + 1'b1;
                end else begin
                    xr <= xr + 1'b1;
                end
            end
            if (v_rise) begin
                y   <= '0;
                yr  <= '0;
                row <= '0;
            end else if (h_rise && (y != Y_W'(V_ACTIVE - 1))) begin
                y <= y + 1'b1;
                if (yr == YR_W'(REGION_H - 1)) begin
                    yr <= '0;
                    if (row != ROW_W'(V_REGIONS - 1)) row <= row + 1'b1;
                end else begin
                    yr <= yr + 1'b1;
                end
            end
        end
    end

    logic [5:0]             sel_idx;
    logic [COLOR_WIDTH-1:0] color_sel;

    always_comb begin
        sel_idx = '0;
        case (split_mode)
            2'd0: sel_idx = '0;
            2'd1: sel_idx = 6'(32'(col));
            2'd2: sel_idx = 6'(32'(row) * H_REGIONS);
            default: sel_idx = 6'(32'(row) * H_REGIONS + 32'(col));
        endcase
        color_sel = '0;
        for (int i = 0; i < N_REGIONS; i++)
            if (sel_idx == 6'(i)) color_sel = colors[i];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Data_VGA <= '0;
        end else if (!De) begin
            Data_VGA <= '0;
        end else begin
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
            Data_VGA <= VGA_Debugg ? COLOR_WIDTH'(sel_idx) : color_sel;
`else
            Data_VGA <= color_sel;
`endif
        end
    end

endmodule

// File: tb/tb_region_color_manager.sv
// Directed bench for region_color_manager: a 2x2 instance plus a 3x2 instance for uneven column split.
module tb_region_color_manager;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       empty_a = 1'b1, empty_b = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       rd_a, rd_b;
    logic       c_rdy = 1'b1;
    logic [5:0] caddr_a, caddr_b;
    logic [7:0] cdata_a, cdata_b;
    logic       cvalid_a, cvalid_b;
    logic       hsync = 1'b0, vsync = 1'b0, de = 1'b0;
    logic [1:0] status_a, status_b, notif_a, notif_b, err_a, err_b, mode_a, mode_b;
    logic       notif_v_a, notif_v_b, err_v_a, err_v_b;
    logic [7:0] vga_a, vga_b;
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
    logic       dbg = 1'b0;
`endif

    always #5 clk = ~clk;

    region_color_manager u_dut (
        .Clk(clk), .Rst(rst_n), .Empty(empty_a), .RXD_Data(data_a), .RXD_Rd(rd_a),
        .C_Rdy(c_rdy), .C_Addr(caddr_a), .C_Data(cdata_a), .C_Valid(cvalid_a),
        .HSync(hsync), .VSync(vsync), .De(de),
        .Config_Status(status_a), .Config_Notification(notif_a),
        .Config_Notification_Valid(notif_v_a), .Config_Error(err_a),
        .Error_Valid(err_v_a), .Split_Mode(mode_a),
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
        .VGA_Debugg(dbg),
`endif
        .Data_VGA(vga_a)
    );

    region_color_manager #(.H_REGIONS(3)) u_dut3 (
        .Clk(clk), .Rst(rst_n), .Empty(empty_b), .RXD_Data(data_b), .RXD_Rd(rd_b),
        .C_Rdy(c_rdy), .C_Addr(caddr_b), .C_Data(cdata_b), .C_Valid(cvalid_b),
        .HSync(hsync), .VSync(vsync), .De(de),
        .Config_Status(status_b), .Config_Notification(notif_b),
        .Config_Notification_Valid(notif_v_b), .Config_Error(err_b),
        .Error_Valid(err_v_b), .Split_Mode(mode_b),
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
        .VGA_Debugg(dbg),
`endif
        .Data_VGA(vga_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pa [640];
    logic [7:0] pb [640];
    logic [7:0] pre_a, post_a;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte on the selected FIFO(s) for a single clock edge.
    task automatic push(input bit to_a, input bit to_b, input logic [7:0] b);
        @(negedge clk);
        if (to_a) begin empty_a = 1'b0; data_a = b; end
        if (to_b) begin empty_b = 1'b0; data_b = b; end
        #1;
        if (to_a) check_val("pop_a", rd_a, 1);
        if (to_b) check_val("pop_b", rd_b, 1);
        @(posedge clk);
        #1;
        empty_a = 1'b1;
        empty_b = 1'b1;
    endtask

    task automatic write_color(input bit to_a, input bit to_b, input logic [5:0] idx, input logic [7:0] c);
        push(to_a, to_b, {2'b00, idx});
        push(to_a, to_b, c);
        cycles(2);
    endtask

    task automatic pixel_line(input int n);
        @(negedge clk);
        de = 1'b1;
        #1 pre_a = vga_a;
        for (int x = 0; x < n; x++) begin
            @(posedge clk);
            #1;
            pa[x] = vga_a;
            pb[x] = vga_b;
        end
        de = 1'b0;
        @(posedge clk);
        #1 post_a = vga_a;
    endtask

    task automatic hsync_n(input int n);
        repeat (n) begin
            @(negedge clk) hsync = 1'b1;
            @(negedge clk) hsync = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        @(negedge clk);
        hsync = 1'b0;
        vsync = 1'b0;
    endtask

    initial begin
        logic held;
        cycles(2);
        check_val("rst_status", status_a, 0);
        check_val("rst_valid", cvalid_a, 0);
        check_val("rst_rd", rd_a, 0);
        check_val("rst_mode", mode_a, 0);
        check_val("rst_vga", vga_a, 0);
        @(negedge clk) rst_n = 1'b1;
        cycles(1);

        // bad region and bad opcode
        push(1, 0, 8'h05);
        check_val("badreg_ev", err_v_a, 1);
        check_val("badreg_code", err_a, 2'b01);
        check_val("badreg_state", status_a, 0);
        cycles(1);
        check_val("err_pulse_len", err_v_a, 0);
        push(1, 0, 8'hC0);
        check_val("badop_ev", err_v_a, 1);
        check_val("badop_code", err_a, 2'b10);
        check_val("badop_state", status_a, 0);

        // timeout fires on the 1024th cycle spent waiting
        push(1, 0, 8'h01);
        check_val("to_wait", status_a, 2'b01);
        cycles(1023);
        check_val("to_early_state", status_a, 2'b01);
        check_val("to_early_ev", err_v_a, 0);
        cycles(1);
        check_val("to_ev", err_v_a, 1);
        check_val("to_code", err_a, 2'b11);
        check_val("to_state", status_a, 0);

        push(1, 0, 8'h01);
        push(1, 0, 8'h22);
        check_val("wr1_valid", cvalid_a, 1);
        check_val("wr1_addr", caddr_a, 1);
        check_val("wr1_data", cdata_a, 8'h22);
        cycles(1);
        check_val("wr1_notif_v", notif_v_a, 1);
        check_val("wr1_notif", notif_a, 2'b01);
        check_val("wr1_valid_off", cvalid_a, 0);

        // stalled handshake, no pop while writing
        c_rdy = 1'b0;
        push(1, 0, 8'h03);
        push(1, 0, 8'h5A);
        check_val("stall_status", status_a, 2'b10);
        check_val("stall_addr", caddr_a, 3);
        check_val("stall_data", cdata_a, 8'h5A);
        empty_a = 1'b0;
        data_a  = 8'hC0;
        #1 check_val("stall_no_pop", rd_a, 0);
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            if (!cvalid_a || notif_v_a || caddr_a != 6'd3) held = 1'b0;
        end
        check_val("stall_hold", held, 1);
        @(negedge clk);
        empty_a = 1'b1;
        c_rdy   = 1'b1;
        cycles(1);
        check_val("stall_valid_off", cvalid_a, 0);
        check_val("stall_notif_v", notif_v_a, 1);
        check_val("stall_notif", notif_a, 2'b01);
        cycles(1);
        check_val("notif_pulse_len", notif_v_a, 0);

        // colors and mode 3 on both instances
        write_color(1, 1, 6'd0, 8'h10);
        write_color(1, 1, 6'd1, 8'h20);
        write_color(1, 1, 6'd2, 8'h30);
        write_color(1, 1, 6'd3, 8'h40);
        push(1, 1, 8'h40);
        push(1, 1, 8'h03);
        check_val("mode3_a", mode_a, 3);
        check_val("mode3_b", mode_b, 3);
        check_val("mode_notif_v", notif_v_a, 1);
        check_val("mode_notif", notif_a, 2'b10);

        frame_start();
        pixel_line(640);
        check_val("lat_pre", pre_a, 0);
        check_val("m3_0_0", pa[0], 8'h10);
        check_val("m3_319_0", pa[319], 8'h10);
        check_val("m3_320_0", pa[320], 8'h20);
        check_val("m3_639_0", pa[639], 8'h20);
        check_val("lat_post", post_a, 0);
        check_val("c3_212", pb[212], 8'h10);
        check_val("c3_213", pb[213], 8'h20);
        check_val("c3_425", pb[425], 8'h20);
        check_val("c3_426", pb[426], 8'h30);
        check_val("c3_639", pb[639], 8'h30);
        hsync_n(239);
        pixel_line(1);
        check_val("m3_0_239", pa[0], 8'h10);
        hsync_n(1);
        pixel_line(1);
        check_val("m3_0_240", pa[0], 8'h30);
        check_val("c3_0_240", pb[0], 8'h40);
        hsync_n(239);
        pixel_line(640);
        check_val("m3_0_479", pa[0], 8'h30);
        check_val("m3_639_479", pa[639], 8'h40);
        check_val("c3_639_479", pb[639], 8'h00);
        hsync_n(3);
        pixel_line(1);
        check_val("y_sat", pa[0], 8'h30);

        // mode 1: columns only
        push(1, 1, 8'h40);
        push(1, 1, 8'h01);
        check_val("mode1_a", mode_a, 1);
        frame_start();
        pixel_line(640);
        check_val("m1_0_0", pa[0], 8'h10);
        check_val("m1_639_0", pa[639], 8'h20);
        hsync_n(479);
        pixel_line(640);
        check_val("m1_0_479", pa[0], 8'h10);
        check_val("m1_639_479", pa[639], 8'h20);

        // reset in the middle of a handshake
        c_rdy = 1'b0;
        push(1, 1, 8'h02);
        push(1, 1, 8'h77);
        check_val("pre_rst_valid", cvalid_a, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid_a", cvalid_a, 0);
        check_val("arst_valid_b", cvalid_b, 0);
        check_val("arst_status", status_a, 0);
        check_val("arst_mode", mode_a, 0);
        check_val("arst_vga", vga_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        c_rdy = 1'b1;
        frame_start();
        pixel_line(1);
        check_val("arst_color0", pa[0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
